// File: rtl/load_store_unit.sv
// Load/store unit for the RV32I core: one request/acknowledge data-bus transaction per access,
// with load alignment/extension, store lane steering and fault reporting.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        stall,
  output logic        wb_en,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_index,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUS, DONE, FAULT} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             is_store_q, is_store_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;

  logic        wb_en_d, fault_d, bus_req_d, bus_we_d;
  logic [31:0] wb_data_d, bus_addr_d, bus_wdata_d;
  logic [4:0]  rd_index_d;
  logic [1:0]  fault_cause_d;
  logic [3:0]  bus_wstrb_d;

  logic        illegal, misaligned;
  logic [3:0]  wstrb_new;
  logic [31:0] wdata_new, shifted, load_val;

  // Access checks and store lane steering for the instruction currently presented.
  always_comb begin
    illegal    = 1'b1;
    misaligned = 1'b0;
    wstrb_new  = 4'b0000;
    wdata_new  = store_data;
    case (funct3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = is_store;
      default:                illegal = 1'b1;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        wstrb_new = 4'b0001 << addr[1:0];
        wdata_new = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb_new = addr[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{store_data[15:0]}};
      end
      default: begin
        wstrb_new = 4'b1111;
        wdata_new = store_data;
      end
    endcase
    if (!is_store) wstrb_new = 4'b0000;
  end

  // Load result alignment uses the offset and width latched at acceptance.
  always_comb begin
    shifted = bus_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    is_store_d    = is_store_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    wb_en_d       = 1'b0;
    fault_d       = 1'b0;
    wb_data_d     = wb_data;
    rd_index_d    = rd_index;
    fault_cause_d = fault_cause;
    bus_req_d     = bus_req;
    bus_we_d      = bus_we;
    bus_addr_d    = bus_addr;
    bus_wstrb_d   = bus_wstrb;
    bus_wdata_d   = bus_wdata;
    stall         = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) begin
          if (illegal || misaligned) begin
            fault_d       = 1'b1;
            fault_cause_d = illegal ? 2'b10 : 2'b01;
            state_d       = FAULT;
          end else begin
            is_store_d  = is_store;
            funct3_d    = funct3;
            off_d       = addr[1:0];
            rd_index_d  = rd_in;
            bus_req_d   = 1'b1;
            bus_we_d    = is_store;
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wstrb_d = wstrb_new;
            bus_wdata_d = wdata_new;
            cnt_d       = '0;
            state_d     = BUS;
          end
        end
      end
      BUS: begin
        stall = 1'b1;
        // An ack in the last counting cycle takes priority over the timeout.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!is_store_q) begin
            wb_data_d = load_val;
            wb_en_d   = 1'b1;
          end
          state_d = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          bus_req_d     = 1'b0;
          fault_d       = 1'b1;
          fault_cause_d = 2'b11;
          state_d       = FAULT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      wb_en       <= 1'b0;
      fault       <= 1'b0;
      wb_data     <= 32'd0;
      rd_index    <= 5'd0;
      fault_cause <= 2'b00;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 32'd0;
      bus_wstrb   <= 4'b0000;
      bus_wdata   <= 32'd0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      is_store_q  <= is_store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      wb_en       <= wb_en_d;
      fault       <= fault_d;
      wb_data     <= wb_data_d;
      rd_index    <= rd_index_d;
      fault_cause <= fault_cause_d;
      bus_req     <= bus_req_d;
      bus_we      <= bus_we_d;
      bus_addr    <= bus_addr_d;
      bus_wstrb   <= bus_wstrb_d;
      bus_wdata   <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit: loads, stores, faults, timeout and reset mid-transaction.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd_in = 5'd0;
  logic        stall, wb_en, fault, bus_req, bus_we;
  logic [31:0] wb_data, bus_addr, bus_wdata;
  logic [4:0]  rd_index;
  logic [1:0]  fault_cause;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations captured by run_access for the calling test to compare.
  int          obs_req_cycles, obs_stall_cycles;
  logic        obs_hung, obs_wb, obs_fault, obs_we, obs_post_wb, obs_post_fault;
  logic [31:0] obs_data, obs_addr, obs_wdata;
  logic [1:0]  obs_cause;
  logic [3:0]  obs_strb;
  logic [4:0]  obs_rd;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .rd_in(rd_in), .stall(stall),
    .wb_en(wb_en), .wb_data(wb_data), .rd_index(rd_index), .fault(fault),
    .fault_cause(fault_cause), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Drives one access from a negedge; ack_at is the 1-based BUS cycle that acks (0 = never).
  task automatic run_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [4:0] rd, input int ack_at,
                            input logic [31:0] rdata);
    obs_req_cycles = 0; obs_stall_cycles = 0; obs_hung = 1'b1;
    obs_wb = 0; obs_fault = 0; obs_data = 0; obs_cause = 0; obs_rd = 0;
    obs_strb = 0; obs_wdata = 0; obs_addr = 0; obs_we = 0;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd_in = rd;
    bus_ack = 1'b0; bus_rdata = rdata;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (!stall) begin
        obs_hung = 1'b0; obs_wb = wb_en; obs_data = wb_data; obs_rd = rd_index;
        obs_fault = fault; obs_cause = fault_cause;
        break;
      end
      obs_stall_cycles++;
      if (bus_req) begin
        obs_req_cycles++;
        obs_strb = bus_wstrb; obs_wdata = bus_wdata; obs_addr = bus_addr; obs_we = bus_we;
        bus_ack = (obs_req_cycles == ack_at);
      end
      @(negedge clk);
    end
    start = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    #1;
    obs_post_wb = wb_en; obs_post_fault = fault;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus_req, wb_en, fault, fault_cause, bus_we, bus_wstrb, stall} !== 11'd0) begin
      n_bad++; $display("[TB] FAIL reset_ctrl got %b expected 0", {bus_req, wb_en, fault, fault_cause, bus_we, bus_wstrb, stall});
    end
    n_cmp++;
    if ({wb_data, rd_index, bus_addr, bus_wdata} !== 101'd0) begin
      n_bad++; $display("[TB] FAIL reset_data got %h expected 0", {wb_data, rd_index, bus_addr, bus_wdata});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw;
    run_access(1'b0, 3'b010, 32'h100, 32'd0, 5'd5, 1, 32'hDEADBEEF);
    n_cmp++;
    if (obs_hung !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_hung got %b expected 0", obs_hung); end
    n_cmp++;
    if (obs_stall_cycles !== 2) begin n_bad++; $display("[TB] FAIL lw_stall got %0d expected 2", obs_stall_cycles); end
    n_cmp++;
    if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_strb !== 4'b0000) begin
      n_bad++; $display("[TB] FAIL lw_bus got addr=%h we=%b strb=%b expected 100/0/0000", obs_addr, obs_we, obs_strb);
    end
    n_cmp++;
    if (obs_wb !== 1'b1 || obs_data !== 32'hDEADBEEF) begin
      n_bad++; $display("[TB] FAIL lw_wb got en=%b data=%h expected 1/deadbeef", obs_wb, obs_data);
    end
    n_cmp++;
    if (obs_rd !== 5'd5) begin n_bad++; $display("[TB] FAIL lw_rd got %0d expected 5", obs_rd); end
    n_cmp++;
    if (obs_post_wb !== 1'b0) begin n_bad++; $display("[TB] FAIL lw_wb_pulse got %b expected 0", obs_post_wb); end
  endtask

  task automatic test_load_extend;
    run_access(1'b0, 3'b000, 32'h103, 32'd0, 5'd1, 1, 32'h80112233);
    n_cmp++;
    if (obs_data !== 32'hFFFFFF80) begin n_bad++; $display("[TB] FAIL lb got %h expected ffffff80", obs_data); end
    run_access(1'b0, 3'b100, 32'h103, 32'd0, 5'd1, 1, 32'h80112233);
    n_cmp++;
    if (obs_data !== 32'h00000080) begin n_bad++; $display("[TB] FAIL lbu got %h expected 00000080", obs_data); end
    run_access(1'b0, 3'b101, 32'h102, 32'd0, 5'd1, 1, 32'h80112233);
    n_cmp++;
    if (obs_data !== 32'h00008011) begin n_bad++; $display("[TB] FAIL lhu got %h expected 00008011", obs_data); end
    run_access(1'b0, 3'b001, 32'h102, 32'd0, 5'd0, 2, 32'h80112233);
    n_cmp++;
    if (obs_data !== 32'hFFFF8011 || obs_wb !== 1'b1) begin
      n_bad++; $display("[TB] FAIL lh_x0 got en=%b data=%h expected 1/ffff8011", obs_wb, obs_data);
    end
    run_access(1'b0, 3'b000, 32'h101, 32'd0, 5'd1, 1, 32'h80112233);
    n_cmp++;
    if (obs_data !== 32'h00000022) begin n_bad++; $display("[TB] FAIL lb_off1 got %h expected 00000022", obs_data); end
  endtask

  task automatic test_store;
    run_access(1'b1, 3'b000, 32'h2, 32'h000000AB, 5'd3, 1, 32'd0);
    n_cmp++;
    if (obs_strb !== 4'b0100 || obs_wdata !== 32'hABABABAB || obs_addr !== 32'h0 || obs_we !== 1'b1) begin
      n_bad++; $display("[TB] FAIL sb got strb=%b wdata=%h addr=%h we=%b expected 0100/abababab/0/1", obs_strb, obs_wdata, obs_addr, obs_we);
    end
    n_cmp++;
    if (obs_wb !== 1'b0 || obs_post_wb !== 1'b0 || obs_fault !== 1'b0) begin
      n_bad++; $display("[TB] FAIL sb_nowb got wb=%b post=%b fault=%b expected 0/0/0", obs_wb, obs_post_wb, obs_fault);
    end
    run_access(1'b1, 3'b001, 32'h206, 32'h1234CDEF, 5'd3, 1, 32'd0);
    n_cmp++;
    if (obs_strb !== 4'b1100 || obs_wdata !== 32'hCDEFCDEF || obs_addr !== 32'h204) begin
      n_bad++; $display("[TB] FAIL sh got strb=%b wdata=%h addr=%h expected 1100/cdefcdef/204", obs_strb, obs_wdata, obs_addr);
    end
    run_access(1'b1, 3'b010, 32'h40, 32'h12345678, 5'd3, 3, 32'd0);
    n_cmp++;
    if (obs_strb !== 4'b1111 || obs_wdata !== 32'h12345678 || obs_req_cycles !== 3) begin
      n_bad++; $display("[TB] FAIL sw got strb=%b wdata=%h req=%0d expected 1111/12345678/3", obs_strb, obs_wdata, obs_req_cycles);
    end
  endtask

  task automatic test_faults;
    run_access(1'b1, 3'b001, 32'h1, 32'h0, 5'd0, 1, 32'd0);
    n_cmp++;
    if (obs_fault !== 1'b1 || obs_cause !== 2'b01 || obs_stall_cycles !== 1 || obs_req_cycles !== 0) begin
      n_bad++; $display("[TB] FAIL sh_misalign got f=%b c=%b st=%0d req=%0d expected 1/01/1/0", obs_fault, obs_cause, obs_stall_cycles, obs_req_cycles);
    end
    n_cmp++;
    if (obs_post_fault !== 1'b0 || obs_post_wb !== 1'b0) begin
      n_bad++; $display("[TB] FAIL fault_pulse got f=%b wb=%b expected 0/0", obs_post_fault, obs_post_wb);
    end
    run_access(1'b0, 3'b011, 32'h100, 32'h0, 5'd2, 1, 32'd0);
    n_cmp++;
    if (obs_fault !== 1'b1 || obs_cause !== 2'b10 || obs_wb !== 1'b0 || obs_req_cycles !== 0) begin
      n_bad++; $display("[TB] FAIL ld_illegal got f=%b c=%b wb=%b req=%0d expected 1/10/0/0", obs_fault, obs_cause, obs_wb, obs_req_cycles);
    end
    run_access(1'b0, 3'b010, 32'h102, 32'h0, 5'd2, 1, 32'd0);
    n_cmp++;
    if (obs_fault !== 1'b1 || obs_cause !== 2'b01) begin
      n_bad++; $display("[TB] FAIL lw_misalign got f=%b c=%b expected 1/01", obs_fault, obs_cause);
    end
    run_access(1'b1, 3'b100, 32'h100, 32'h0, 5'd2, 1, 32'd0);
    n_cmp++;
    if (obs_fault !== 1'b1 || obs_cause !== 2'b10) begin
      n_bad++; $display("[TB] FAIL st_illegal got f=%b c=%b expected 1/10", obs_fault, obs_cause);
    end
    run_access(1'b0, 3'b111, 32'h101, 32'h0, 5'd2, 1, 32'd0);
    n_cmp++;
    if (obs_fault !== 1'b1 || obs_cause !== 2'b10) begin
      n_bad++; $display("[TB] FAIL illegal_prio got f=%b c=%b expected 1/10", obs_fault, obs_cause);
    end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 5'd7, 0, 32'h11111111);
    n_cmp++;
    if (obs_req_cycles !== 16 || obs_fault !== 1'b1 || obs_cause !== 2'b11 || obs_wb !== 1'b0) begin
      n_bad++; $display("[TB] FAIL timeout got req=%0d f=%b c=%b wb=%b expected 16/1/11/0", obs_req_cycles, obs_fault, obs_cause, obs_wb);
    end
    #1;
    n_cmp++;
    if (bus_req !== 1'b0) begin n_bad++; $display("[TB] FAIL timeout_req got %b expected 0", bus_req); end
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 5'd7, 16, 32'h22222222);
    n_cmp++;
    if (obs_req_cycles !== 16 || obs_fault !== 1'b0 || obs_wb !== 1'b1 || obs_data !== 32'h22222222) begin
      n_bad++; $display("[TB] FAIL late_ack got req=%0d f=%b wb=%b d=%h expected 16/0/1/22222222", obs_req_cycles, obs_fault, obs_wb, obs_data);
    end
  endtask

  task automatic test_reset_in_bus;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h500; rd_in = 5'd9; bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (bus_req !== 1'b1 || stall !== 1'b1) begin
      n_bad++; $display("[TB] FAIL bus3 got req=%b stall=%b expected 1/1", bus_req, stall);
    end
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus_req !== 1'b0 || wb_en !== 1'b0 || fault !== 1'b0 || stall !== 1'b0) begin
      n_bad++; $display("[TB] FAIL rst_bus got req=%b wb=%b f=%b stall=%b expected 0/0/0/0", bus_req, wb_en, fault, stall);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (wb_en !== 1'b0 || fault !== 1'b0) begin
      n_bad++; $display("[TB] FAIL rst_after got wb=%b f=%b expected 0/0", wb_en, fault);
    end
    @(negedge clk);
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 5'd4, 1, 32'hCAFEF00D);
    n_cmp++;
    if (obs_hung !== 1'b0 || obs_wb !== 1'b1 || obs_data !== 32'hCAFEF00D || obs_rd !== 5'd4) begin
      n_bad++; $display("[TB] FAIL lw_after_rst got h=%b wb=%b d=%h rd=%0d expected 0/1/cafef00d/4", obs_hung, obs_wb, obs_data, obs_rd);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_faults();
    test_timeout();
    test_reset_in_bus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
